// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad digit-entry front end.
// Key lines are handled up to MAX_KEYS wide; callers zero-extend narrower vectors.
package keypad_pkg;

  localparam int DIGIT_W  = 4;
  localparam int MAX_KEYS = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } key_state_t;

  function automatic logic onehot_valid(input logic [MAX_KEYS-1:0] code);
    int n;
    n = 0;
    for (int i = 0; i < MAX_KEYS; i++) begin
      n += int'(code[i]);
    end
    return (n == 1);
  endfunction

  function automatic logic [DIGIT_W-1:0] onehot_to_index(input logic [MAX_KEYS-1:0] code);
    logic [DIGIT_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_KEYS; i++) begin
      if (code[i]) idx = DIGIT_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Key-line synchroniser and press/release debounce FSM; emits one accept pulse per press.
//
//   state    | meaning
//   IDLE     | no key held, waiting for a single valid key
//   DEBOUNCE | valid key seen, counting identical samples down to zero
//   HELD     | digit accepted, waiting for all keys released
//   RELEASE  | keys released, counting zero samples before re-arming
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int NUM_KEYS        = 10,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] keypad_buttons,
  output logic                accept,
  output logic [DIGIT_W-1:0]  digit
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LOAD = DW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] sync1, sync2;
  logic [NUM_KEYS-1:0] code_q, code_n;
  logic [DW-1:0]       cnt, cnt_n;
  key_state_t          state, state_n;
  logic                sample_valid, sample_zero;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      state  <= IDLE;
      code_q <= '0;
      cnt    <= '0;
    end else begin
      sync1  <= keypad_buttons;
      sync2  <= sync1;
      state  <= state_n;
      code_q <= code_n;
      cnt    <= cnt_n;
    end
  end

  assign sample_valid = onehot_valid(MAX_KEYS'(sync2));
  assign sample_zero  = (sync2 == '0);
  assign digit        = onehot_to_index(MAX_KEYS'(code_q));

  always_comb begin
    state_n = state;
    code_n  = code_q;
    cnt_n   = cnt;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (sample_valid) begin
          state_n = DEBOUNCE;
          code_n  = sync2;
          cnt_n   = DB_LOAD;
        end
      end
      DEBOUNCE: begin
        if (sync2 == code_q) begin
          if (cnt == '0) begin
            accept  = 1'b1;
            state_n = HELD;
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end else if (sample_valid) begin
          code_n = sync2;
          cnt_n  = DB_LOAD;
        end else begin
          state_n = IDLE;
        end
      end
      HELD: begin
        // invalid multi-key codes keep us here; only a full release re-arms
        if (sample_zero) begin
          state_n = RELEASE;
          cnt_n   = DB_LOAD;
        end
      end
      RELEASE: begin
        if (!sample_zero) begin
          state_n = HELD;
        end else if (cnt == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/keypad_entry_buffer.sv
// Keypad digit-entry buffer: debounced digits shift into an N-digit register
// with saturating count, full handling, synchronous clear and idle auto-clear.
module keypad_entry_buffer
  import keypad_pkg::*;
#(
  parameter int NUM_KEYS        = 10,
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 0,
  parameter int FULL_MODE       = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_KEYS-1:0]               keypad_buttons,
  input  logic                              clear_entry,
  output logic [DIGIT_W*NUM_DIGITS-1:0]     keypad_values,
  output logic                              shift_pulse,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count,
  output logic                              entry_full,
  output logic                              timeout_pulse
);

  localparam int VW = DIGIT_W * NUM_DIGITS;
  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(NUM_DIGITS);
  localparam logic [TW-1:0] TMR_LOAD = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

  logic               accept;
  logic [DIGIT_W-1:0] digit;
  logic [TW-1:0]      timer;
  logic               do_shift, fire;

  keypad_debounce #(
    .NUM_KEYS        (NUM_KEYS),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk            (clk),
    .reset          (reset),
    .keypad_buttons (keypad_buttons),
    .accept         (accept),
    .digit          (digit)
  );

  assign entry_full = (digit_count == FULL_CNT);
  assign do_shift   = accept && !(entry_full && (FULL_MODE != 0));
  // an accept in the expiry cycle restarts the timer instead of clearing
  assign fire       = (TIMEOUT_CYCLES > 0) && (digit_count != '0) && (timer == '0) && !accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      keypad_values <= '0;
      digit_count   <= '0;
      timer         <= TMR_LOAD;
      shift_pulse   <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      shift_pulse   <= 1'b0;
      timeout_pulse <= 1'b0;
      if (clear_entry) begin
        keypad_values <= '0;
        digit_count   <= '0;
        timer         <= TMR_LOAD;
      end else if (accept) begin
        timer <= TMR_LOAD;
        if (do_shift) begin
          keypad_values <= (keypad_values << DIGIT_W) | VW'(digit);
          shift_pulse   <= 1'b1;
          if (digit_count != FULL_CNT) digit_count <= digit_count + 1'b1;
        end
      end else if (fire) begin
        keypad_values <= '0;
        digit_count   <= '0;
        timer         <= TMR_LOAD;
        timeout_pulse <= 1'b1;
      end else if ((digit_count != '0) && (timer != '0)) begin
        timer <= timer - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Bench for keypad_entry_buffer: three instances (default, FULL_MODE=1, TIMEOUT_CYCLES=50)
// checked against an event-level reference model of the entry register.
module tb_keypad_entry_buffer;

  localparam int D  = 4;
  localparam int ND = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  keys [3];
  logic        clr  [3];
  logic [15:0] vals [3];
  logic        sp   [3];
  logic [2:0]  cnt  [3];
  logic        full [3];
  logic        tp   [3];

  logic [15:0] m_vals [3];
  int          m_cnt [3], m_age [3], m_sp_cnt [3], m_to_cnt [3];
  int          sched [3];
  logic [3:0]  sdig [3];
  int          a_sp_cnt [3], a_to_cnt [3];
  int          edge_cnt;
  int          n_checks, n_errors;

  always #5 clk = ~clk;

  keypad_entry_buffer #(.NUM_KEYS(10), .NUM_DIGITS(4), .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(0), .FULL_MODE(0)) dut0 (
    .clk(clk), .reset(rst), .keypad_buttons(keys[0]), .clear_entry(clr[0]), .keypad_values(vals[0]),
    .shift_pulse(sp[0]), .digit_count(cnt[0]), .entry_full(full[0]), .timeout_pulse(tp[0]));
  keypad_entry_buffer #(.NUM_KEYS(10), .NUM_DIGITS(4), .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(0), .FULL_MODE(1)) dut1 (
    .clk(clk), .reset(rst), .keypad_buttons(keys[1]), .clear_entry(clr[1]), .keypad_values(vals[1]),
    .shift_pulse(sp[1]), .digit_count(cnt[1]), .entry_full(full[1]), .timeout_pulse(tp[1]));
  keypad_entry_buffer #(.NUM_KEYS(10), .NUM_DIGITS(4), .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(50), .FULL_MODE(0)) dut2 (
    .clk(clk), .reset(rst), .keypad_buttons(keys[2]), .clear_entry(clr[2]), .keypad_values(vals[2]),
    .shift_pulse(sp[2]), .digit_count(cnt[2]), .entry_full(full[2]), .timeout_pulse(tp[2]));

  function automatic int full_mode_of(input int d);
    return (d == 1) ? 1 : 0;
  endfunction

  function automatic int timeout_of(input int d);
    return (d == 2) ? 50 : 0;
  endfunction

  function automatic bit is_onehot(input logic [9:0] c);
    return $countones(c) == 1;
  endfunction

  function automatic logic [3:0] key_index(input logic [9:0] c);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 10; i++) if (c[i]) r = 4'(i);
    return r;
  endfunction

  // Reference model: a scheduled accept edge per instance, entry register as a digit shift,
  // idle age counted in edges since the last accepted key.
  always @(posedge clk) begin
    edge_cnt = edge_cnt + 1;
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        m_vals[d] = '0; m_cnt[d] = 0; m_age[d] = 0; sched[d] = -1;
      end else begin
        bit acc;
        acc = (sched[d] == edge_cnt);
        if (acc) sched[d] = -1;
        if (clr[d]) begin
          m_vals[d] = '0; m_cnt[d] = 0; m_age[d] = 0;
        end else if (acc) begin
          m_age[d] = 0;
          if (!(m_cnt[d] == ND && full_mode_of(d) == 1)) begin
            m_vals[d] = {m_vals[d][11:0], sdig[d]};
            m_cnt[d]  = (m_cnt[d] < ND) ? m_cnt[d] + 1 : ND;
            m_sp_cnt[d]++;
          end
        end else if (timeout_of(d) > 0 && m_cnt[d] > 0) begin
          m_age[d]++;
          if (m_age[d] == timeout_of(d)) begin
            m_vals[d] = '0; m_cnt[d] = 0; m_age[d] = 0;
            m_to_cnt[d]++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (sp[d] === 1'b1) a_sp_cnt[d]++;
      if (tp[d] === 1'b1) a_to_cnt[d]++;
    end
  end

  task automatic press(input logic [2:0] mask, input logic [9:0] code, input int hold,
                       input int gap, input int clr_at);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      if (mask[d]) begin
        if (is_onehot(code) && hold >= D + 1) begin
          sched[d] = edge_cnt + D + 3;
          sdig[d]  = key_index(code);
        end
        keys[d] = code;
      end
    end
    for (int i = 0; i < hold; i++) begin
      for (int d = 0; d < 3; d++) if (mask[d] && i == clr_at) clr[d] = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 3; d++) clr[d] = 1'b0;
    end
    for (int d = 0; d < 3; d++) if (mask[d]) keys[d] = '0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if ({vals[d], cnt[d], full[d], sp[d], tp[d]} !== 24'h0) begin
        n_errors++;
        $display("FAIL reset_outputs dut%0d: vals=%h cnt=%0d full=%b sp=%b tp=%b, required all zero",
                 d, vals[d], cnt[d], full[d], sp[d], tp[d]);
      end
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fill;
    int s [3];
    for (int d = 0; d < 3; d++) s[d] = a_sp_cnt[d];
    press(3'b111, 10'h002, 10, 10, -1);
    press(3'b111, 10'h004, 10, 10, -1);
    press(3'b111, 10'h008, 10, 10, -1);
    press(3'b111, 10'h010, 10, 10, -1);
    #1;
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (vals[d] !== 16'h1234 || cnt[d] !== 3'd4 || full[d] !== 1'b1) begin
        n_errors++;
        $display("FAIL fill dut%0d: vals=%h cnt=%0d full=%b, required 1234 4 1", d, vals[d], cnt[d], full[d]);
      end
      n_checks++;
      if (a_sp_cnt[d] - s[d] !== 4) begin
        n_errors++;
        $display("FAIL fill_pulses dut%0d: got %0d shift pulses, required 4", d, a_sp_cnt[d] - s[d]);
      end
    end
  endtask

  task automatic test_full_mode;
    int s0, s1;
    s0 = a_sp_cnt[0]; s1 = a_sp_cnt[1];
    press(3'b111, 10'h080, 10, 10, -1);
    #1;
    n_checks++;
    if (vals[0] !== 16'h2347 || a_sp_cnt[0] - s0 !== 1 || cnt[0] !== 3'd4) begin
      n_errors++;
      $display("FAIL full_shift dut0: vals=%h pulses=%0d cnt=%0d, required 2347 1 4", vals[0], a_sp_cnt[0] - s0, cnt[0]);
    end
    n_checks++;
    if (vals[1] !== 16'h1234 || a_sp_cnt[1] - s1 !== 0 || cnt[1] !== 3'd4) begin
      n_errors++;
      $display("FAIL full_ignore dut1: vals=%h pulses=%0d cnt=%0d, required 1234 0 4", vals[1], a_sp_cnt[1] - s1, cnt[1]);
    end
  endtask

  task automatic test_glitch_invalid;
    int s0, s1;
    s0 = a_sp_cnt[0]; s1 = a_sp_cnt[1];
    press(3'b111, 10'h020, 2, 10, -1);
    press(3'b111, 10'h003, 20, 10, -1);
    #1;
    n_checks++;
    if (vals[0] !== 16'h2347 || vals[1] !== 16'h1234 || a_sp_cnt[0] !== s0 || a_sp_cnt[1] !== s1) begin
      n_errors++;
      $display("FAIL glitch_invalid: vals0=%h vals1=%h pulses0=%0d pulses1=%0d, required 2347 1234 0 0",
               vals[0], vals[1], a_sp_cnt[0] - s0, a_sp_cnt[1] - s1);
    end
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (vals[d] !== m_vals[d] || cnt[d] !== 3'(m_cnt[d])) begin
        n_errors++;
        $display("FAIL glitch_model dut%0d: vals=%h cnt=%0d, required %h %0d", d, vals[d], cnt[d], m_vals[d], m_cnt[d]);
      end
    end
  endtask

  task automatic test_hold_latency;
    int e0, lat, s;
    s = a_sp_cnt[0];
    @(negedge clk);
    e0 = edge_cnt; sched[0] = e0 + D + 3; sdig[0] = 4'd9; keys[0] = 10'h200;
    lat = -1;
    for (int i = 0; i < 20 && lat < 0; i++) begin
      @(negedge clk);
      if (sp[0] === 1'b1) lat = edge_cnt - e0;
    end
    n_checks++;
    if (lat !== D + 3) begin
      n_errors++;
      $display("FAIL accept_latency: got %0d cycles (-1 = none), required %0d", lat, D + 3);
    end
    n_checks++;
    if (vals[0][3:0] !== 4'd9) begin
      n_errors++;
      $display("FAIL held_digit: low digit %0d, required 9", vals[0][3:0]);
    end
    repeat (100 - (edge_cnt - e0)) @(negedge clk);
    keys[0] = '0;   @(negedge clk);
    keys[0] = 10'h200; @(negedge clk);
    keys[0] = '0;   repeat (20) @(negedge clk);
    #1;
    n_checks++;
    if (a_sp_cnt[0] - s !== 1 || vals[0] !== m_vals[0]) begin
      n_errors++;
      $display("FAIL hold_bounce: pulses=%0d vals=%h, required 1 %h", a_sp_cnt[0] - s, vals[0], m_vals[0]);
    end
  endtask

  task automatic test_timeout;
    int t_sp, t_to, s;
    @(negedge clk); clr[2] = 1'b1;
    @(negedge clk); clr[2] = 1'b0;
    sched[2] = edge_cnt + D + 3; sdig[2] = 4'd5; keys[2] = 10'h020;
    t_sp = -1;
    for (int i = 0; i < 20 && t_sp < 0; i++) begin
      @(negedge clk);
      if (sp[2] === 1'b1) t_sp = edge_cnt;
    end
    n_checks++;
    if (t_sp < 0 || vals[2] !== 16'h0005 || cnt[2] !== 3'd1) begin
      n_errors++;
      $display("FAIL timeout_digit: seen=%0d vals=%h cnt=%0d, required pulse 0005 1", t_sp >= 0, vals[2], cnt[2]);
    end
    repeat (4) @(negedge clk);
    keys[2] = '0;
    t_to = -1;
    for (int i = 0; i < 100 && t_to < 0; i++) begin
      @(negedge clk);
      if (tp[2] === 1'b1) t_to = edge_cnt;
    end
    n_checks++;
    if (t_to < 0 || t_to - t_sp !== 50) begin
      n_errors++;
      $display("FAIL timeout_delay: got %0d cycles (seen=%0d), required 50", t_to - t_sp, t_to >= 0);
    end
    n_checks++;
    if (vals[2] !== 16'h0 || cnt[2] !== 3'd0) begin
      n_errors++;
      $display("FAIL timeout_clear: vals=%h cnt=%0d, required 0 0", vals[2], cnt[2]);
    end
    s = a_sp_cnt[2];
    @(negedge clk);
    sched[2] = edge_cnt + D + 3; sdig[2] = 4'd3; keys[2] = 10'h008;
    for (int i = 0; i < 20 && edge_cnt != sched[2] - 1; i++) @(negedge clk);
    clr[2] = 1'b1;
    @(negedge clk);
    clr[2] = 1'b0;
    n_checks++;
    if (sp[2] !== 1'b0 || vals[2] !== 16'h0 || cnt[2] !== 3'd0) begin
      n_errors++;
      $display("FAIL clear_vs_accept: sp=%b vals=%h cnt=%0d, required 0 0 0", sp[2], vals[2], cnt[2]);
    end
    repeat (10) @(negedge clk);
    keys[2] = '0;
    repeat (15) @(negedge clk);
    #1;
    n_checks++;
    if (a_sp_cnt[2] !== s) begin
      n_errors++;
      $display("FAIL clear_vs_accept_pulses: got %0d shift pulses, required 0", a_sp_cnt[2] - s);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    @(negedge clk);
    keys[0] = 10'h040;
    for (int phase = 0; phase < 2; phase++) begin
      repeat (phase == 0 ? 3 : 12) @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++;
      if ({vals[0], cnt[0], full[0], sp[0], tp[0], vals[1]} !== 40'h0) begin
        n_errors++;
        $display("FAIL reset_mid phase%0d: vals0=%h cnt0=%0d full0=%b vals1=%h, required all zero",
                 phase, vals[0], cnt[0], full[0], vals[1]);
      end
      @(negedge clk);
      rst = 1'b0;
      sched[0] = edge_cnt + D + 3; sdig[0] = 4'd6;
      lat = -1;
      for (int i = 0, e0 = edge_cnt; i < 20 && lat < 0; i++) begin
        @(negedge clk);
        if (sp[0] === 1'b1) lat = edge_cnt - e0;
      end
      n_checks++;
      if (lat !== D + 3 || vals[0] !== 16'h0006 || cnt[0] !== 3'd1) begin
        n_errors++;
        $display("FAIL reset_redebounce phase%0d: latency=%0d vals=%h cnt=%0d, required %0d 0006 1",
                 phase, lat, vals[0], cnt[0], D + 3);
      end
    end
    keys[0] = '0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_random;
    logic [9:0] code;
    logic [2:0] mask;
    int a, b, clr_at;
    for (int n = 0; n < 40; n++) begin
      mask = 3'($urandom_range(1, 7));
      a = $urandom_range(0, 9);
      code = 10'(1) << a;
      if ($urandom_range(0, 9) == 0) begin
        b = (a + $urandom_range(1, 9)) % 10;
        code = code | (10'(1) << b);
      end
      clr_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : -1;
      press(mask, code, $urandom_range(1, 25), $urandom_range(8, 20), clr_at);
      #1;
      for (int d = 0; d < 3; d++) begin
        n_checks++;
        if (vals[d] !== m_vals[d] || cnt[d] !== 3'(m_cnt[d]) || full[d] !== (m_cnt[d] == ND)) begin
          n_errors++;
          $display("FAIL random_entry n=%0d dut%0d: vals=%h cnt=%0d full=%b, required %h %0d %b",
                   n, d, vals[d], cnt[d], full[d], m_vals[d], m_cnt[d], m_cnt[d] == ND);
        end
      end
    end
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (a_sp_cnt[d] !== m_sp_cnt[d] || a_to_cnt[d] !== m_to_cnt[d]) begin
        n_errors++;
        $display("FAIL pulse_totals dut%0d: shift=%0d timeout=%0d, required %0d %0d",
                 d, a_sp_cnt[d], a_to_cnt[d], m_sp_cnt[d], m_to_cnt[d]);
      end
    end
  endtask

  initial begin
    edge_cnt = 0; n_checks = 0; n_errors = 0;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      keys[d] = '0; clr[d] = 1'b0; m_vals[d] = '0; m_cnt[d] = 0; m_age[d] = 0;
      m_sp_cnt[d] = 0; m_to_cnt[d] = 0; sched[d] = -1; sdig[d] = '0;
      a_sp_cnt[d] = 0; a_to_cnt[d] = 0;
    end
    test_reset();
    test_fill();
    test_full_mode();
    test_glitch_invalid();
    test_hold_latency();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
